// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async FIFO write and read controllers.
//   - ADDRESS_WIDTH_DFLT / PTR_W : default address width and pointer width
//                                  (pointer carries one extra wrap bit)
//   - FN_W                       : working width of the Gray helpers
//   - bin2gray / gray2bin        : width-generic conversions. Callers
//                                  zero-extend into FN_W bits and truncate
//                                  the result to their own pointer width.
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int ADDRESS_WIDTH_DFLT = 4;
   localparam int PTR_W              = ADDRESS_WIDTH_DFLT + 1;
   localparam int FN_W               = 32;

   function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it. Zero-extended
   // upper bits contribute nothing, so any narrower width converts correctly.
   function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
      logic [FN_W-1:0] b;
      b = '0;
      for (int i = 0; i < FN_W; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl_if
// Signal bundle between the write-side controller and its environment
// (producer, memory and read-domain pointer).
//   master : producer side; drives W_INC, OVF_CLR and presents RD_PTR_GRAY
//   slave  : the controller; drives the strobe, address, pointer and flags
//
// Handshake: W_INC is a request that may be held high at any time. A write
// is taken on a rising CLK edge only when W_INC is high and FULL is low;
// WR_EN shows that combinationally (WR_EN = W_INC & !FULL) in the same cycle.
// A request while FULL is dropped (not queued) and latches OVERFLOW.
// -----------------------------------------------------------------------------
interface fifo_wr_ctrl_if #(
   parameter int ADDRESS_WIDTH = 4
);
   logic                     W_INC;
   logic [ADDRESS_WIDTH:0]   RD_PTR_GRAY;
   logic                     OVF_CLR;
   logic                     WR_EN;
   logic [ADDRESS_WIDTH-1:0] WR_ADDR;
   logic [ADDRESS_WIDTH:0]   WR_PTR_GRAY;
   logic                     FULL;
   logic                     ALMOST_FULL;
   logic [ADDRESS_WIDTH:0]   WR_LEVEL;
   logic                     OVERFLOW;

   modport master (
      output W_INC, RD_PTR_GRAY, OVF_CLR,
      input  WR_EN, WR_ADDR, WR_PTR_GRAY, FULL, ALMOST_FULL, WR_LEVEL, OVERFLOW
   );

   modport slave (
      input  W_INC, RD_PTR_GRAY, OVF_CLR,
      output WR_EN, WR_ADDR, WR_PTR_GRAY, FULL, ALMOST_FULL, WR_LEVEL, OVERFLOW
   );
endinterface

// File: rtl/ptr_sync.sv
// -----------------------------------------------------------------------------
// ptr_sync
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Plain flop chain with nothing between stages.
//   CLK : destination clock
//   RST : asynchronous reset, active-low
//   D   : pointer from the other clock domain
//   Q   : pointer after STAGES flops
// -----------------------------------------------------------------------------
module ptr_sync
   import fifo_pkg::*;
#(
   parameter int WIDTH  = PTR_W,
   parameter int STAGES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] sync_q [STAGES];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= D;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign Q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-domain controller of the async FIFO. Keeps the binary/Gray write
// pointer, synchronises the read pointer into CLK and derives FULL,
// ALMOST_FULL, the fill level and a sticky OVERFLOW.
//   CLK  : write-domain clock
//   RST  : asynchronous reset, active-low (released synchronously upstream)
//   bus  : slave modport of fifo_wr_ctrl_if
//          in : W_INC, RD_PTR_GRAY (async), OVF_CLR
//          out: WR_EN (comb), WR_ADDR, WR_PTR_GRAY, FULL, ALMOST_FULL,
//               WR_LEVEL, OVERFLOW (all registered)
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int AF_THRESH     = 14
) (
   input  logic         CLK,
   input  logic         RST,
   fifo_wr_ctrl_if.slave bus
);

   localparam int AW = ADDRESS_WIDTH;
   localparam int PW = ADDRESS_WIDTH + 1;

   logic [PW-1:0] wbin;
   logic [PW-1:0] wgray;
   logic [PW-1:0] wbin_n;
   logic [PW-1:0] wgray_n;
   logic [PW-1:0] rq;
   logic [PW-1:0] rbin;
   logic [PW-1:0] level_n;
   logic [PW-1:0] level_q;
   logic          full_q;
   logic          full_n;
   logic          af_q;
   logic          ovf_q;
   logic          accept;

   ptr_sync #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_rd_sync (
      .CLK (CLK),
      .RST (RST),
      .D   (bus.RD_PTR_GRAY),
      .Q   (rq)
   );

   assign rbin    = PW'(gray2bin(FN_W'(rq)));
   assign accept  = bus.W_INC & ~full_q;
   assign wbin_n  = wbin + PW'(accept);
   assign wgray_n = PW'(bin2gray(FN_W'(wbin_n)));

   // Full when the next write pointer has lapped the synchronised read pointer
   // by exactly one depth: top two Gray bits inverted, the rest equal. The
   // read pointer is stale by the sync delay, so FULL only errs on the safe
   // side (held longer than strictly needed).
   assign full_n  = (wgray_n == {~rq[AW:AW-1], rq[AW-2:0]});
   assign level_n = wbin_n - rbin;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wbin    <= '0;
         wgray   <= '0;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wbin    <= wbin_n;
         wgray   <= wgray_n;
         full_q  <= full_n;
         af_q    <= (level_n >= PW'(AF_THRESH));
         level_q <= level_n;
         // A dropped request sets the flag even if a clear arrives with it.
         ovf_q   <= (bus.W_INC & full_q) | (ovf_q & ~bus.OVF_CLR);
      end
   end

   assign bus.WR_EN       = accept;
   assign bus.WR_ADDR     = wbin[AW-1:0];
   assign bus.WR_PTR_GRAY = wgray;
   assign bus.FULL        = full_q;
   assign bus.ALMOST_FULL = af_q;
   assign bus.WR_LEVEL    = level_q;
   assign bus.OVERFLOW    = ovf_q;

endmodule
